mem_master: RTL
===============

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter PROT_TOP, default 16'h0200, meaning first writable address when protection is compiled in.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, requester has a command.
REQ-005 SHALL have port req_ready, output, 1, block can accept a command.
REQ-006 SHALL have port req_op, input, 2, command: 00 read byte, 01 read word, 10 write byte, 11 write word.
REQ-007 SHALL have port req_addr, input, 16, byte address.
REQ-008 SHALL have port req_wdata, input, 16, write data; byte writes use [7:0].
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 16, read result; byte reads zero-extended.
REQ-011 SHALL have port rsp_err, output, 1, write refused; valid with rsp_valid.
REQ-012 SHALL have port mem_addr, output, 16, address to memory.
REQ-013 SHALL have port mem_din, output, 8, write data to memory.
REQ-014 SHALL have port mem_we, output, 1, memory write enable.
REQ-015 SHALL have port mem_dout, input, 8, combinational read data from memory at mem_addr.

Function
REQ-016 SHALL implement FSM states IDLE, ACC0, ACC1, RESP; req_ready = (state==IDLE) and not in reset.
REQ-017 SHALL accept a command on a rising edge with req_valid&&req_ready, latching op, addr and wdata, and move to ACC0.
REQ-018 SHALL, in ACC0, drive mem_addr=addr; for a write it SHALL drive mem_we=1 and mem_din=wdata[7:0] (byte) or wdata[15:8] (word).
REQ-019 SHALL, in ACC1 (word ops only), drive mem_addr=addr+1 modulo 2^16 (0xFFFF wraps to 0x0000) and, for write word, mem_we=1, mem_din=wdata[7:0].
REQ-020 SHALL store words big-endian: byte at addr is bits [15:8], byte at addr+1 is bits [7:0].
REQ-021 SHALL sample mem_dout at the end of ACC0 into rsp_rdata[15:8] for word reads, [7:0] for byte reads (upper cleared), and at the end of ACC1 into [7:0].
REQ-022 SHALL drive all mem_* outputs and rsp_* outputs from registers; mem_we SHALL be 0 in IDLE and RESP.
REQ-023 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; latency from accepting edge to rsp_valid high: byte ops 2 cycles, word ops 3 cycles.
REQ-024 SHALL hold rsp_rdata unchanged across write commands and until the next read completes.
REQ-025 SHALL ignore req_* whenever req_ready is low; no queuing, no response backpressure.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, req_ready=0, mem_we=0, mem_addr=0, mem_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, immediately.
REQ-027 SHALL abort any in-flight command on reset with no response and no further memory write; req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with MEM_MASTER_PROT_EN defined, refuse writes whose addr (or, for word writes, addr or addr+1 after wrap) is below PROT_TOP: no mem_we pulse, same latency, rsp_err=1 with rsp_valid.
REQ-029 SHALL, without MEM_MASTER_PROT_EN, perform all writes and tie rsp_err to 0; PROT_TOP unused.

Structure
REQ-030 SHALL place the req_op encodings and the FSM state type in shared package mem_master_pkg.
REQ-031 SHALL place the protection comparison in sub-module mem_master_prot, instantiated only under MEM_MASTER_PROT_EN.

Verification
REQ-032 SHALL verify byte read: model mem[0x0001]=0x05, op 00 addr 0x0001 -> rsp_valid 2 cycles after accept, rsp_rdata=0x0005.
REQ-033 SHALL verify word read wrap: mem[0xFFFF]=0x12, mem[0x0000]=0xBB, op 01 addr 0xFFFF -> rsp_rdata=0x12BB after 3 cycles, mem_addr sequence 0xFFFF,0x0000.
REQ-034 SHALL verify word write: op 11 addr 0x0300 wdata 0xA55A -> mem[0x0300]=0xA5, mem[0x0301]=0x5A, exactly two mem_we cycles, rsp_err=0.
REQ-035 SHALL verify protection (macro on, PROT_TOP=0x0200): write byte addr 0x01FF data 0x77 -> no mem_we, rsp_err=1, memory unchanged; write word 0xFFFF -> rsp_err=1.
REQ-036 SHALL verify reset mid-word-write: assert rst during ACC0 of op 11 addr 0x0400 -> mem_we drops immediately, mem[0x0401] unchanged, no rsp_valid, req_ready=1 one cycle after release.
REQ-037 SHALL verify back-to-back: req_valid held high with two commands -> second accepted only in the IDLE cycle after RESP; req_ready low throughout ACC0..RESP.

Source files
------------

// File: rtl/mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_master_pkg
//   Definitions shared by the mem_master block and its protection sub-module:
//   the request opcode encoding, the FSM state type and two small helpers
//   that decode an opcode into its "is a write" and "is a word" properties.
// -----------------------------------------------------------------------------
package mem_master_pkg;

    // Request opcodes. Bit 1 selects write, bit 0 selects a 16-bit word.
    typedef enum logic [1:0] {
        OP_RD_BYTE = 2'b00,
        OP_RD_WORD = 2'b01,
        OP_WR_BYTE = 2'b10,
        OP_WR_WORD = 2'b11
    } op_e;

    // Controller states: wait for a command, first byte access, second byte
    // access (word ops only), one-cycle response.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

    function automatic logic op_is_write(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_word(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/mem_master_prot.sv
// -----------------------------------------------------------------------------
// mem_master_prot
//   Write-protection check for mem_master. A write is refused when any byte
//   it would touch lies below PROT_TOP. For word writes the second byte is at
//   addr+1 with 16-bit wrap, so a word write at 0xFFFF touches 0x0000.
//   Instantiated by mem_master only when MEM_MASTER_PROT_EN is defined.
//
// Parameters
//   PROT_TOP  first writable byte address
// Ports
//   op      in   command opcode (reads are never refused)
//   addr    in   command byte address
//   refuse  out  1 = this command is a write that must not reach memory
// -----------------------------------------------------------------------------
module mem_master_prot
    import mem_master_pkg::*;
#(
    parameter logic [15:0] PROT_TOP = 16'h0200
) (
    input  op_e         op,
    input  logic [15:0] addr,
    output logic        refuse
);

    logic [15:0] addr_next;
    logic        low_first;
    logic        low_second;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (here unconditionally) so no latch can be inferred.
    always_comb begin
        addr_next  = addr + 16'd1;
        low_first  = (addr < PROT_TOP);
        low_second = op_is_word(op) && (addr_next < PROT_TOP);
        refuse     = op_is_write(op) && (low_first || low_second);
    end

endmodule

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//   Byte-wide memory controller that turns byte/word read/write commands into
//   one or two single-byte memory accesses. Words are big-endian: the byte at
//   addr carries bits [15:8], the byte at addr+1 (16-bit wrap) bits [7:0].
//
//   Timing (E0 = accepting edge):
//     byte op : ACC0 -> RESP, rsp_valid high in the cycle ending at E0+2
//     word op : ACC0 -> ACC1 -> RESP, rsp_valid high in the cycle ending at E0+3
//   All mem_* and rsp_* outputs come straight from flops. req_ready is the
//   only combinational output: IDLE and not in reset.
//
//   Build option: define MEM_MASTER_PROT_EN to refuse writes touching any
//   address below PROT_TOP (no mem_we, same latency, rsp_err=1). Without it
//   every write is performed and rsp_err stays 0.
//
// Parameters
//   PROT_TOP   first writable address when protection is compiled in
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   requester has a command
//   req_ready  out  block can accept a command
//   req_op     in   00 rd byte, 01 rd word, 10 wr byte, 11 wr word
//   req_addr   in   byte address
//   req_wdata  in   write data (byte writes use [7:0])
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  read result, byte reads zero-extended; held over writes
//   rsp_err    out  write refused, valid with rsp_valid
//   mem_addr   out  memory address
//   mem_din    out  memory write data
//   mem_we     out  memory write enable
//   mem_dout   in   combinational memory read data at mem_addr
// -----------------------------------------------------------------------------
module mem_master
    import mem_master_pkg::*;
#(
    parameter logic [15:0] PROT_TOP = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    // Controller state and latched command
    state_e      state_q,     state_d;
    op_e         op_q,        op_d;
    logic [15:0] addr_q,      addr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic        refuse_q,    refuse_d;
    // High byte of a word read, parked until the low byte arrives so that
    // rsp_rdata changes only when the read completes.
    logic [7:0]  rd_hi_q,     rd_hi_d;

    // Registered outputs
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_din_q,   mem_din_d;
    logic        mem_we_q,    mem_we_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;

    op_e         req_op_e;
    logic        accept;
    logic        refuse_now;

    assign req_op_e  = op_e'(req_op);
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef MEM_MASTER_PROT_EN
    mem_master_prot #(
        .PROT_TOP (PROT_TOP)
    ) u_prot (
        .op     (req_op_e),
        .addr   (req_addr),
        .refuse (refuse_now)
    );
`else
    // Without protection the limit has no effect; fold it into a sink so the
    // parameter stays part of the interface in every build.
    logic unused_prot_top;
    assign unused_prot_top = ^PROT_TOP;
    assign refuse_now      = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first -- everything holds except the strobes
        // (mem_we, rsp_valid, rsp_err), which fall back to 0 each cycle. This
        // also keeps the block free of inferred latches.
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        refuse_d    = refuse_q;
        rd_hi_d     = rd_hi_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = req_op_e;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    refuse_d   = refuse_now;
                    // Set up the first access so it is on the pins in ACC0.
                    mem_addr_d = req_addr;
                    mem_we_d   = op_is_write(req_op_e) && !refuse_now;
                    mem_din_d  = op_is_word(req_op_e) ? req_wdata[15:8]
                                                      : req_wdata[7:0];
                    state_d    = ACC0;
                end
            end

            ACC0: begin
                if (op_is_word(op_q)) begin
                    rd_hi_d    = mem_dout;
                    // Second byte; 16-bit add wraps 0xFFFF to 0x0000.
                    mem_addr_d = addr_q + 16'd1;
                    mem_we_d   = (op_q == OP_WR_WORD) && !refuse_q;
                    mem_din_d  = wdata_q[7:0];
                    state_d    = ACC1;
                end else begin
                    if (op_q == OP_RD_BYTE) begin
                        rsp_rdata_d = {8'h00, mem_dout};
                    end
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = refuse_q;
                    state_d     = RESP;
                end
            end

            ACC1: begin
                if (op_q == OP_RD_WORD) begin
                    rsp_rdata_d = {rd_hi_q, mem_dout};
                end
                rsp_valid_d = 1'b1;
                rsp_err_d   = refuse_q;
                state_d     = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset aborts any command in flight: the
    // write strobe and response pulse drop immediately and nothing resumes.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD_BYTE;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            refuse_q    <= 1'b0;
            rd_hi_q     <= 8'h00;
            mem_addr_q  <= 16'h0000;
            mem_din_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            refuse_q    <= refuse_d;
            rd_hi_q     <= rd_hi_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
